// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// mem_port_arbiter : N-channel single-port memory arbiter, fixed-latency read
//                    return steered back to the requesting channel.
// Rev 1.0
// ============================================================================
module mem_port_arbiter #(
   parameter int NCH  = 2,
   parameter int AW   = 32,
   parameter int DW   = 32,
   parameter int LAT  = 1,
   parameter int PRIO = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NCH-1:0]    req,
   input  logic [NCH*AW-1:0] addr,
   input  logic [NCH-1:0]    we,
   input  logic [NCH*3-1:0]  func,
   input  logic [NCH*DW-1:0] wdata,
   output logic [NCH-1:0]    gnt,
   output logic [NCH-1:0]    rvalid,
   output logic [DW-1:0]     rdata,
   output logic              mem_en,
   output logic              mem_we,
   output logic [AW-1:0]     mem_addr,
   output logic [2:0]        mem_func,
   output logic [DW-1:0]     mem_wdata,
   input  logic [DW-1:0]     mem_rdata
);

   localparam int             c_idw  = (NCH > 1) ? $clog2(NCH) : 1;
   localparam logic [c_idw-1:0] c_last = c_idw'(NCH - 1);

   logic [c_idw-1:0] r_ptr;
   logic             r_pv  [LAT];
   logic [c_idw-1:0] r_pid [LAT];

   logic             w_any;
   logic [c_idw-1:0] w_gid;
   logic [NCH-1:0]   w_gnt;
   logic             w_ret;
   logic [NCH-1:0]   w_rvalid;

   // Scan channels starting at the round-robin pointer (or at 0 for fixed priority).
   always_comb begin
      int v_idx;
      v_idx = 0;
      w_any = 1'b0;
      w_gid = '0;
      w_gnt = '0;
      for (int k = 0; k < NCH; k++) begin
         v_idx = (PRIO == 0) ? int'(r_ptr) + k : k;
         if (v_idx >= NCH) v_idx = v_idx - NCH;
         if (!w_any && rst && req[v_idx]) begin
            w_any = 1'b1;
            w_gid = v_idx[c_idw-1:0];
         end
      end
      if (w_any) w_gnt[w_gid] = 1'b1;
   end

   assign gnt       = w_gnt;
   assign mem_en    = w_any;
   assign mem_we    = w_any & we[w_gid];
   assign mem_addr  = addr[w_gid*AW +: AW];
   assign mem_func  = func[w_gid*3 +: 3];
   assign mem_wdata = wdata[w_gid*DW +: DW];

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_ptr <= '0;
         for (int s = 0; s < LAT; s++) begin
            r_pv[s]  <= 1'b0;
            r_pid[s] <= '0;
         end
      end else begin
         if (w_any) r_ptr <= (w_gid == c_last) ? '0 : w_gid + 1'b1;
         r_pv[0]  <= w_any & ~we[w_gid];
         r_pid[0] <= w_gid;
         for (int s = 1; s < LAT; s++) begin
            r_pv[s]  <= r_pv[s-1];
            r_pid[s] <= r_pid[s-1];
         end
      end
   end

   // Return is gated by rst so nothing leaks out during the reset cycle itself.
   assign w_ret = rst & r_pv[LAT-1];

   always_comb begin
      w_rvalid = '0;
      if (w_ret) w_rvalid[r_pid[LAT-1]] = 1'b1;
   end

   assign rvalid = w_rvalid;
   assign rdata  = w_ret ? mem_rdata : '0;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// tb_mem_port_arbiter : three arbiter configurations checked every cycle against
// a behavioural model, plus directed scenarios with literal expectations.
module tb_mem_port_arbiter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic         rstn   [3];
   logic [3:0]   req    [3];
   logic [127:0] addr   [3];
   logic [3:0]   we     [3];
   logic [11:0]  func   [3];
   logic [127:0] wdata  [3];
   logic [31:0]  mrd    [3];
   logic [3:0]   gnt    [3];
   logic [3:0]   rv     [3];
   logic [31:0]  rdata  [3];
   logic         men    [3];
   logic         mwe    [3];
   logic [31:0]  maddr  [3];
   logic [2:0]   mfunc  [3];
   logic [31:0]  mwdata [3];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int ncfg(input int c);
      return (c == 0) ? 2 : (c == 1) ? 4 : 3;
   endfunction

   task automatic set_ch(input int c, input int ch, input logic [31:0] a, input logic w,
                         input logic [2:0] f, input logic [31:0] d);
      addr[c][ch*32 +: 32]  = a;
      we[c][ch]             = w;
      func[c][ch*3 +: 3]    = f;
      wdata[c][ch*32 +: 32] = d;
   endtask

   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   task automatic smp();
      @(negedge clk);
   endtask

   // Config 0: NCH=2 LAT=1 RR.  Config 1: NCH=4 LAT=3 fixed.  Config 2: NCH=3 LAT=2 RR.
   for (genvar c = 0; c < 3; c++) begin : g_cfg
      localparam int N = (c == 0) ? 2 : (c == 1) ? 4 : 3;
      localparam int L = (c == 0) ? 1 : (c == 1) ? 3 : 2;
      localparam int P = (c == 1) ? 1 : 0;

      logic [N-1:0] gnt_w;
      logic [N-1:0] rv_w;

      mem_port_arbiter #(.NCH(N), .AW(32), .DW(32), .LAT(L), .PRIO(P)) u_dut (
         .clk       (clk),
         .rst       (rstn[c]),
         .req       (req[c][N-1:0]),
         .addr      (addr[c][N*32-1:0]),
         .we        (we[c][N-1:0]),
         .func      (func[c][N*3-1:0]),
         .wdata     (wdata[c][N*32-1:0]),
         .gnt       (gnt_w),
         .rvalid    (rv_w),
         .rdata     (rdata[c]),
         .mem_en    (men[c]),
         .mem_we    (mwe[c]),
         .mem_addr  (maddr[c]),
         .mem_func  (mfunc[c]),
         .mem_wdata (mwdata[c]),
         .mem_rdata (mrd[c])
      );

      assign gnt[c] = 4'(gnt_w);
      assign rv[c]  = 4'(rv_w);

      // Model: pointer as an integer, returns as a queue of (due cycle, channel).
      int ptr = 0;
      int cyc = 0;
      int due_q[$];
      int ch_q[$];
      int waitc[N];

      always @(negedge clk) begin
         int          g;
         int          ch;
         logic [3:0]  eg;
         logic [3:0]  erv;
         logic [31:0] erd;
         logic        ewe;
         g = -1;
         if (rstn[c] && req[c][N-1:0] != '0) begin
            for (int k = 0; k < N; k++) begin
               ch = (P == 1) ? k : (ptr + k) % N;
               if (g < 0 && req[c][ch]) g = ch;
            end
         end
         eg  = (g >= 0) ? 4'(1 << g) : 4'd0;
         ewe = 1'b0;
         if (g >= 0) ewe = we[c][g];
         erv = '0;
         erd = '0;
         if (due_q.size() > 0 && due_q[0] == cyc) begin
            if (rstn[c]) begin
               erv = 4'(1 << ch_q[0]);
               erd = mrd[c];
            end
            void'(due_q.pop_front());
            void'(ch_q.pop_front());
         end

         chk($sformatf("c%0d gnt", c), 64'(gnt[c]), 64'(eg));
         chk($sformatf("c%0d mem_en", c), 64'(men[c]), 64'(g >= 0));
         chk($sformatf("c%0d mem_we", c), 64'(mwe[c]), 64'(ewe));
         if (g >= 0) begin
            chk($sformatf("c%0d mem_addr", c), 64'(maddr[c]), 64'(addr[c][g*32 +: 32]));
            chk($sformatf("c%0d mem_func", c), 64'(mfunc[c]), 64'(func[c][g*3 +: 3]));
            chk($sformatf("c%0d mem_wdata", c), 64'(mwdata[c]), 64'(wdata[c][g*32 +: 32]));
         end
         chk($sformatf("c%0d rvalid", c), 64'(rv[c]), 64'(erv));
         chk($sformatf("c%0d rdata", c), 64'(rdata[c]), 64'(erd));

         for (int k = 0; k < N; k++) begin
            if (rstn[c] && req[c][k] && !eg[k]) waitc[k]++;
            else waitc[k] = 0;
            if (P == 0 && waitc[k] > 0)
               chk($sformatf("c%0d starve ch%0d", c, k), 64'(waitc[k] < N), 64'd1);
         end

         if (!rstn[c]) begin
            ptr = 0;
            due_q.delete();
            ch_q.delete();
         end else if (g >= 0) begin
            ptr = (g + 1) % N;
            if (!we[c][g]) begin
               due_q.push_back(cyc + L);
               ch_q.push_back(g);
            end
         end
         cyc++;
      end
   end

   logic [3:0] eg41  [5] = '{4'd1, 4'd2, 4'd1, 4'd2, 4'd0};
   logic [3:0] erv41 [5] = '{4'd0, 4'd1, 4'd2, 4'd1, 4'd2};
   logic [3:0] lastg [3];

   initial begin
      int nc;
      for (int c = 0; c < 3; c++) begin
         rstn[c] = 1'b0; req[c] = '0; addr[c] = '0; we[c] = '0;
         func[c] = '0; wdata[c] = '0; mrd[c] = '0; lastg[c] = '0;
      end
      nxt();
      nxt();

      // Reset masks requests
      req[0] = 4'b0011;
      smp();
      chk("rst gnt", 64'(gnt[0]), 64'd0);
      chk("rst mem_en", 64'(men[0]), 64'd0);
      chk("rst mem_we", 64'(mwe[0]), 64'd0);
      chk("rst rvalid", 64'(rv[0]), 64'd0);
      chk("rst rdata", 64'(rdata[0]), 64'd0);
      nxt();
      for (int c = 0; c < 3; c++) rstn[c] = 1'b1;

      // Single ch0 read, LAT=1
      req[0] = 4'b0001;
      set_ch(0, 0, 32'h10, 1'b0, 3'b010, 32'h0);
      smp();
      chk("rd0 gnt", 64'(gnt[0]), 64'd1);
      chk("rd0 mem_en", 64'(men[0]), 64'd1);
      chk("rd0 mem_addr", 64'(maddr[0]), 64'h10);
      chk("rd0 rdata idle", 64'(rdata[0]), 64'd0);
      nxt();
      req[0] = 4'b0000;
      mrd[0] = 32'hDEADBEEF;
      smp();
      chk("rd0 rvalid", 64'(rv[0]), 64'd1);
      chk("rd0 rdata", 64'(rdata[0]), 64'hDEADBEEF);
      nxt();
      rstn[0] = 1'b0;
      nxt();
      rstn[0] = 1'b1;

      // Both channels held, alternating grants and returns
      req[0] = 4'b0011;
      set_ch(0, 1, 32'h20, 1'b0, 3'b000, 32'h0);
      for (int i = 0; i < 5; i++) begin
         mrd[0] = 32'h100 + i;
         if (i == 4) req[0] = 4'b0000;
         smp();
         chk($sformatf("rr gnt[%0d]", i), 64'(gnt[0]), 64'(eg41[i]));
         chk($sformatf("rr rvalid[%0d]", i), 64'(rv[0]), 64'(erv41[i]));
         if (i > 0) chk($sformatf("rr rdata[%0d]", i), 64'(rdata[0]), 64'(32'h100 + i));
         nxt();
      end

      // ch1 write, no return
      req[0] = 4'b0010;
      set_ch(0, 1, 32'h2C, 1'b1, 3'b010, 32'h12345678);
      smp();
      chk("wr gnt", 64'(gnt[0]), 64'd2);
      chk("wr mem_en", 64'(men[0]), 64'd1);
      chk("wr mem_we", 64'(mwe[0]), 64'd1);
      chk("wr mem_addr", 64'(maddr[0]), 64'h2C);
      chk("wr mem_wdata", 64'(mwdata[0]), 64'h12345678);
      chk("wr mem_func", 64'(mfunc[0]), 64'd2);
      nxt();
      req[0] = 4'b0000;
      for (int i = 0; i < 5; i++) begin
         smp();
         chk($sformatf("wr rvalid[%0d]", i), 64'(rv[0]), 64'd0);
         nxt();
      end

      // Fixed priority, LAT=3
      req[1] = 4'b1110;
      set_ch(1, 1, 32'h100, 1'b0, 3'b010, 32'h0);
      set_ch(1, 2, 32'h200, 1'b0, 3'b010, 32'h0);
      set_ch(1, 3, 32'h300, 1'b0, 3'b010, 32'h0);
      for (int i = 0; i < 7; i++) begin
         if (i == 3) req[1] = 4'b0000;
         smp();
         chk($sformatf("pr gnt[%0d]", i), 64'(gnt[1]), (i < 3) ? 64'd2 : 64'd0);
         chk($sformatf("pr rvalid[%0d]", i), 64'(rv[1]), (i >= 3 && i < 6) ? 64'd2 : 64'd0);
         nxt();
      end

      // LAT=2 read discarded by reset
      req[2] = 4'b0001;
      set_ch(2, 0, 32'h40, 1'b0, 3'b000, 32'h0);
      smp();
      chk("rf gnt", 64'(gnt[2]), 64'd1);
      nxt();
      req[2] = 4'b0000;
      rstn[2] = 1'b0;
      smp();
      chk("rf rvalid[0]", 64'(rv[2]), 64'd0);
      nxt();
      rstn[2] = 1'b1;
      for (int i = 1; i < 4; i++) begin
         smp();
         chk($sformatf("rf rvalid[%0d]", i), 64'(rv[2]), 64'd0);
         nxt();
      end
      req[2] = 4'b0011;
      set_ch(2, 1, 32'h44, 1'b0, 3'b000, 32'h0);
      smp();
      chk("rf first gnt", 64'(gnt[2]), 64'd1);
      nxt();
      req[2] = 4'b0010;
      smp();
      chk("rf second gnt", 64'(gnt[2]), 64'd2);
      nxt();
      req[2] = 4'b0000;
      smp();
      chk("rf ret0", 64'(rv[2]), 64'd1);
      nxt();
      smp();
      chk("rf ret1", 64'(rv[2]), 64'd2);
      nxt();

      // ptr=2: ch2 read beats ch0 write
      req[2] = 4'b0101;
      set_ch(2, 0, 32'h80, 1'b1, 3'b001, 32'hCAFE0000);
      set_ch(2, 2, 32'h84, 1'b0, 3'b100, 32'h0);
      smp();
      chk("p2 gnt", 64'(gnt[2]), 64'd4);
      chk("p2 mem_we", 64'(mwe[2]), 64'd0);
      nxt();
      req[2] = 4'b0001;
      smp();
      chk("p2 gnt next", 64'(gnt[2]), 64'd1);
      chk("p2 mem_we next", 64'(mwe[2]), 64'd1);
      chk("p2 rvalid early", 64'(rv[2]), 64'd0);
      nxt();
      req[2] = 4'b0000;
      for (int i = 0; i < 3; i++) begin
         smp();
         chk($sformatf("p2 rvalid[%0d]", i), 64'(rv[2]), (i == 0) ? 64'd4 : 64'd0);
         nxt();
      end

      // Randomized traffic with held requests and occasional reset pulses
      for (int n = 0; n < 3000; n++) begin
         for (int c = 0; c < 3; c++) begin
            nc = ncfg(c);
            rstn[c] = ($urandom_range(99) != 0);
            for (int ch = 0; ch < nc; ch++) begin
               if (req[c][ch] && lastg[c][ch]) req[c][ch] = 1'b0;
               if (!req[c][ch] && $urandom_range(1) == 1) begin
                  req[c][ch] = 1'b1;
                  set_ch(c, ch, $urandom, ($urandom_range(2) == 0),
                         3'($urandom_range(7)), $urandom);
               end
            end
            mrd[c] = $urandom;
         end
         smp();
         for (int c = 0; c < 3; c++) lastg[c] = gnt[c];
         nxt();
      end

      for (int c = 0; c < 3; c++) begin
         req[c] = '0;
         rstn[c] = 1'b1;
      end
      repeat (6) nxt();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
